mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port memory between an instruction-fetch requester (IF)
// and a data-memory requester (DM). Each access owns the memory for
// WAIT_CYCLES cycles (SERVE), then the owner gets a one-cycle Done pulse
// (RESP). When both requesters contend, the one not served last wins.
//
// Parameters
//   WAIT_CYCLES  memory access latency in cycles, legal range 1..15
//
// Ports
//   CLK, RST          clock (rising edge), asynchronous active-high reset
//   IfReq/IfAddr      fetch request (held until IfDone) and byte address
//   IfDone/IfRdData   fetch completion pulse and fetched word
//   DmReq/DmWr        data request (held until DmDone), 1 = store
//   DmAddr/DmWrData   data byte address and store data
//   DmDone/DmRdData   data completion pulse and load result
//   MemEn/MemWr       shared memory enable / write strobe
//   MemAddr/MemWrData shared memory address / write data
//   MemRdData         shared memory read data
//   Stall             high while any request is pending or in service
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IfReq,
    input  logic [31:0] IfAddr,
    output logic        IfDone,
    output logic [31:0] IfRdData,
    input  logic        DmReq,
    input  logic        DmWr,
    input  logic [31:0] DmAddr,
    input  logic [31:0] DmWrData,
    output logic        DmDone,
    output logic [31:0] DmRdData,
    output logic        MemEn,
    output logic        MemWr,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWrData,
    input  logic [31:0] MemRdData,
    output logic        Stall
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    // Counter preload so that SERVE lasts exactly WAIT_CYCLES cycles
    // (it counts down to zero inclusive).
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    owner_t      owner_q, owner_d;
    owner_t      lastGnt_q, lastGnt_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] ifRdData_q, ifRdData_d;
    logic [31:0] dmRdData_q, dmRdData_d;

    // State register. LastGnt resets to DM so that a simultaneous first
    // request after reset goes to IF.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            lastGnt_q  <= OWN_DM;
            cnt_q      <= 4'd0;
            ifRdData_q <= 32'd0;
            dmRdData_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            lastGnt_q  <= lastGnt_d;
            cnt_q      <= cnt_d;
            ifRdData_q <= ifRdData_d;
            dmRdData_q <= dmRdData_d;
        end
    end

    // Next-state logic: arbitration in IDLE, countdown and read capture in
    // SERVE, round-robin bookkeeping in RESP. Request inputs are not looked
    // at during SERVE, so a dropped request still completes.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        lastGnt_d  = lastGnt_q;
        cnt_d      = cnt_q;
        ifRdData_d = ifRdData_q;
        dmRdData_d = dmRdData_q;
        case (state_q)
            IDLE: begin
                if (IfReq || DmReq) begin
                    if (IfReq && DmReq) begin
                        owner_d = (lastGnt_q == OWN_IF) ? OWN_DM : OWN_IF;
                    end else if (DmReq) begin
                        owner_d = OWN_DM;
                    end else begin
                        owner_d = OWN_IF;
                    end
                    cnt_d   = CNT_LOAD;
                    state_d = SERVE;
                end
            end
            SERVE: begin
                if (cnt_q == 4'd0) begin
                    // Memory data is valid in the last SERVE cycle only;
                    // stores leave the load result untouched.
                    if (owner_q == OWN_IF) begin
                        ifRdData_d = MemRdData;
                    end else if (!DmWr) begin
                        dmRdData_d = MemRdData;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                lastGnt_d = owner_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode: the memory bus is only driven in SERVE and is zero
    // otherwise; Done goes to the owner during RESP.
    always_comb begin
        MemEn     = 1'b0;
        MemWr     = 1'b0;
        MemAddr   = 32'd0;
        MemWrData = 32'd0;
        IfDone    = 1'b0;
        DmDone    = 1'b0;
        case (state_q)
            SERVE: begin
                MemEn = 1'b1;
                if (owner_q == OWN_DM) begin
                    MemWr     = DmWr;
                    MemAddr   = DmAddr;
                    MemWrData = DmWrData;
                end else begin
                    MemAddr = IfAddr;
                end
            end
            RESP: begin
                if (owner_q == OWN_DM) begin
                    DmDone = 1'b1;
                end else begin
                    IfDone = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign IfRdData = ifRdData_q;
    assign DmRdData = dmRdData_q;

    // Stall drops in the Done cycle so a sole requester can advance.
    assign Stall = (IfReq | DmReq) & ~(IfDone | DmDone);

endmodule
